// File: rtl/uart_hex_pkg.sv
// rtl/uart_hex_pkg.sv - shared state encodings, ASCII constants and nibble encoder for uart_hex_tx
package uart_hex_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_HEX,
    SEQ_TERM,
    SEQ_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_M10 = 8'h37;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_0 + {4'd0, nib};
    end
    return ASCII_A_M10 + {4'd0, nib};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 single-byte serializer with gapless byte_valid/byte_ready handoff
module uart_tx_byte
  import uart_hex_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  ser_state_t  state, state_next;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg, shreg_next;
  logic        bit_end;
  logic        load;

  always_comb begin
    bit_end    = (state != SER_IDLE) && (baud_cnt == BAUD_LAST);
    byte_ready = (state == SER_IDLE) || ((state == SER_STOP) && bit_end);
    state_next = state;
    load       = 1'b0;
    case (state)
      SER_IDLE: begin
        if (byte_valid) begin
          state_next = SER_START;
          load       = 1'b1;
        end
      end
      SER_START: begin
        if (bit_end) state_next = SER_DATA;
      end
      SER_DATA: begin
        if (bit_end && (bit_cnt == 3'd7)) state_next = SER_STOP;
      end
      SER_STOP: begin
        // Accepting here chains the next start bit directly after this stop bit.
        if (bit_end) begin
          if (byte_valid) begin
            state_next = SER_START;
            load       = 1'b1;
          end else begin
            state_next = SER_IDLE;
          end
        end
      end
      default: state_next = SER_IDLE;
    endcase
    shreg_next = shreg;
    if (load) begin
      shreg_next = byte_data;
    end else if ((state == SER_DATA) && bit_end) begin
      shreg_next = {1'b0, shreg[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SER_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'd0;
      tx       <= 1'b1;
    end else begin
      shreg <= shreg_next;
      if (load || bit_end || (state == SER_IDLE)) begin
        baud_cnt <= 16'd0;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
      if (load) begin
        bit_cnt <= 3'd0;
      end else if ((state == SER_DATA) && bit_end) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      // Registered line driver, so the pin follows the state being entered.
      case (state_next)
        SER_START: tx <= 1'b0;
        SER_DATA:  tx <= shreg_next[0];
        default:   tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_tx.sv
// rtl/uart_hex_tx.sv - word to ASCII hex UART sender; UART_HEX_CRLF_EN selects CR LF terminator instead of space
module uart_hex_tx
  import uart_hex_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int MAX_NIB  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 snd_start,
  input  logic [4*MAX_NIB-1:0] snd_data,
  input  logic [4:0]           snd_nibbles,
  output logic                 snd_busy,
  output logic                 snd_done,
  output logic                 fpga_tx
);

  localparam int NIB_W = (MAX_NIB > 1) ? $clog2(MAX_NIB) : 1;
`ifdef UART_HEX_CRLF_EN
  localparam logic [1:0] TERM_LAST = 2'd1;
`else
  localparam logic [1:0] TERM_LAST = 2'd0;
`endif

  seq_state_t           seq, seq_next;
  logic [4*MAX_NIB-1:0] data_q;
  logic [NIB_W-1:0]     nib_idx;
  logic [1:0]           term_idx;
  logic [4:0]           nib_clamped;
  logic [3:0]           digit;
  logic                 accept;
  logic                 xfer;
  logic                 busy_next;
  logic                 byte_valid;
  logic                 byte_ready;
  logic [7:0]           byte_data;

  always_comb begin
    nib_clamped = ((snd_nibbles == 5'd0) || (snd_nibbles > 5'(MAX_NIB))) ? 5'(MAX_NIB) : snd_nibbles;
    digit       = data_q[{nib_idx, 2'b00} +: 4];
    seq_next    = seq;
    accept      = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = ASCII_SPACE;
    case (seq)
      SEQ_IDLE: begin
        if (snd_start) begin
          accept   = 1'b1;
          seq_next = SEQ_HEX;
        end
      end
      SEQ_HEX: begin
        byte_valid = 1'b1;
        byte_data  = nib2ascii(digit);
        if (byte_ready && (nib_idx == '0)) seq_next = SEQ_TERM;
      end
      SEQ_TERM: begin
        if (term_idx <= TERM_LAST) begin
          byte_valid = 1'b1;
`ifdef UART_HEX_CRLF_EN
          byte_data  = (term_idx == 2'd0) ? ASCII_CR : ASCII_LF;
`else
          byte_data  = ASCII_SPACE;
`endif
        end else if (byte_ready) begin
          // Serializer is in the last cycle of the final stop bit.
          seq_next = SEQ_DONE;
        end
      end
      SEQ_DONE: seq_next = SEQ_IDLE;
      default:  seq_next = SEQ_IDLE;
    endcase
    xfer      = byte_valid && byte_ready;
    busy_next = ((seq == SEQ_HEX) || (seq == SEQ_TERM)) && (seq_next != SEQ_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq <= SEQ_IDLE;
    end else begin
      seq <= seq_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snd_busy <= 1'b0;
      data_q   <= '0;
      nib_idx  <= '0;
      term_idx <= 2'd0;
    end else begin
      snd_busy <= busy_next;
      if (accept) begin
        data_q   <= snd_data;
        nib_idx  <= NIB_W'(nib_clamped - 5'd1);
        term_idx <= 2'd0;
      end else if (xfer && (seq == SEQ_HEX)) begin
        nib_idx <= nib_idx - 1'b1;
      end else if (xfer && (seq == SEQ_TERM)) begin
        term_idx <= term_idx + 2'd1;
      end
    end
  end

  assign snd_done = (seq == SEQ_DONE);

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx_byte (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .tx        (fpga_tx)
  );

endmodule
